// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch address generator feeding a DEPTH-entry {pc, instr} queue
module fetch_queue #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exti_miss,
    input  logic [ILEN-1:0]            exti_data,
    output logic [XLEN-1:0]            exto_addr,
    output logic                       exto_req,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [XLEN-1:0]            deq_pc,
    output logic [ILEN-1:0]            deq_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] INC = XLEN'(ILEN/8);
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(ILEN/8 - 1);
    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic deq, enq;
    assign exto_addr = fpc;
    assign deq_valid = count != '0;
    assign deq = deq_valid & deq_ready;
    assign exto_req = ~rst & (count < CW'(DEPTH) | deq) & ~redirect_valid;
    assign enq = exto_req & ~exti_miss;
    assign deq_pc = pc_mem[head];
    assign deq_instr = instr_mem[head];
    // control state: redirect flushes everything left after this cycle's dequeue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc <= RESET_PC;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            fpc <= redirect_pc & ALIGN;
            head <= tail;
            count <= '0;
        end else begin
            if (deq) head <= head + AW'(1);
            if (enq) begin
                tail <= tail + AW'(1);
                fpc <= fpc + INC;
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end
    // queue storage, written only on enqueue and never reset
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail] <= fpc;
            instr_mem[tail] <= exti_data;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random and directed checks of fetch_queue against a queue-based model
module tb_fetch_queue;
    logic clk = 0, rst = 1, exti_miss = 1, redirect_valid = 0, deq_ready = 0;
    logic [31:0] exti_data = 0, redirect_pc = 0;
    logic [31:0] exto_addr, deq_pc, deq_instr;
    logic exto_req, deq_valid;
    logic [2:0] count;
    int n_checks = 0, n_fail = 0;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t q[$];
    logic [31:0] m_fpc = 0;

    fetch_queue dut (
        .clk(clk), .rst(rst), .exti_miss(exti_miss), .exti_data(exti_data),
        .exto_addr(exto_addr), .exto_req(exto_req), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .deq_ready(deq_ready), .deq_valid(deq_valid),
        .deq_pc(deq_pc), .deq_instr(deq_instr), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_state();
        check("deq_valid", 64'(deq_valid), 64'(q.size() != 0));
        check("count", 64'(count), 64'(q.size()));
        check("exto_addr", 64'(exto_addr), 64'(m_fpc));
        if (q.size() != 0) begin
            check("deq_pc", 64'(deq_pc), 64'(q[0].pc));
            check("deq_instr", 64'(deq_instr), 64'(q[0].instr));
        end
    endtask

    task automatic step(input logic m, input logic rv, input logic rdy, input logic [31:0] rp);
        logic [31:0] d;
        logic dq, rq;
        d = $urandom;
        cmp_state();
        exti_miss = m;
        exti_data = d;
        redirect_valid = rv;
        redirect_pc = rp;
        deq_ready = rdy;
        dq = q.size() != 0 && rdy;
        rq = (q.size() < 4 || dq) && !rv;
        #1 check("exto_req", 64'(exto_req), 64'(rq));
        @(posedge clk);
        if (dq) void'(q.pop_front());
        if (rv) begin
            q.delete();
            m_fpc = rp & ~32'h3;
        end else if (rq && !m) begin
            q.push_back('{pc: m_fpc, instr: d});
            m_fpc += 4;
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(deq_valid), 64'(0));
        check("rst_req", 64'(exto_req), 64'(0));
        check("rst_addr", 64'(exto_addr), 64'(0));
        rst = 0;
        repeat (4) step(0, 0, 0, 0);
        check("fill_count", 64'(count), 64'(4));
        check("fill_addr", 64'(exto_addr), 64'h10);
        #1 check("fill_req", 64'(exto_req), 64'(0));
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("stream_pc", 64'(deq_pc), 64'(4 * i));
            check("stream_count", 64'(count), 64'(4));
            step(0, 0, 1, 0);
        end
        step(0, 1, 0, 32'h20);
        for (int i = 0; i < 3; i++) begin
            check("miss_addr", 64'(exto_addr), 64'h20);
            step(1, 0, 0, 0);
        end
        check("miss_count", 64'(count), 64'(0));
        step(0, 0, 0, 0);
        check("miss_enq_pc", 64'(deq_pc), 64'h20);
        step(0, 1, 0, 32'h40);
        repeat (3) step(0, 0, 0, 0);
        check("redir_pre_count", 64'(count), 64'(3));
        step(0, 1, 1, 32'h103);
        check("redir_count", 64'(count), 64'(0));
        check("redir_addr", 64'(exto_addr), 64'h100);
        step(0, 0, 0, 0);
        check("redir_deq_pc", 64'(deq_pc), 64'h100);
        step(0, 1, 1, 32'h500);
        step(0, 1, 1, 32'hFFFFFFFE);
        step(0, 0, 0, 0);
        check("wrap_pc", 64'(deq_pc), 64'hFFFFFFFC);
        check("wrap_addr", 64'(exto_addr), 64'h0);
        step(0, 1, 0, 32'h200);
        repeat (2) step(0, 0, 0, 0);
        check("arst_pre_count", 64'(count), 64'(2));
        exti_miss = 1;
        deq_ready = 0;
        redirect_valid = 0;
        #1 rst = 1;
        #1 check("arst_valid", 64'(deq_valid), 64'(0));
        check("arst_count", 64'(count), 64'(0));
        check("arst_req", 64'(exto_req), 64'(0));
        q.delete();
        m_fpc = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1 check("arst_addr", 64'(exto_addr), 64'h0);
        @(negedge clk);
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFE0 | 32'($urandom_range(0, 31))) : $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, rp);
        end
        cmp_state();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32: address/PC width in bits.
REQ-002 Parameter ILEN, default 32: instruction width in bits; ILEN/8 is the PC increment.
REQ-003 Parameter DEPTH, default 4: queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0: fetch address after reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 exti_miss  in  1  external instruction memory cannot return data this cycle.
REQ-008 exti_data  in  ILEN  instruction at exto_addr, valid when exti_miss=0.
REQ-009 exto_addr  out  XLEN  fetch address presented to instruction memory.
REQ-010 exto_req  out  1  fetch request valid this cycle.
REQ-011 redirect_valid  in  1  flush queue and restart fetch (mispredict/jump).
REQ-012 redirect_pc  in  XLEN  restart address.
REQ-013 deq_ready  in  1  decode stage accepts the head entry.
REQ-014 deq_valid  out  1  head entry valid.
REQ-015 deq_pc  out  XLEN  PC of head entry.
REQ-016 deq_instr  out  ILEN  instruction of head entry.
REQ-017 count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-018 Internal state: fetch PC fpc, circular buffer of DEPTH {pc, instr} entries, head/tail pointers, count.
REQ-019 exto_addr SHALL equal fpc combinationally.
REQ-020 deq SHALL be deq_valid & deq_ready; exto_req SHALL be (count<DEPTH | deq) & ~redirect_valid.
REQ-021 enq SHALL be exto_req & ~exti_miss; on enq, {fpc, exti_data} written at tail, tail advances, fpc <= fpc + ILEN/8.
REQ-022 exti_miss=1: no enqueue, fpc holds, exto_addr stays stable until a non-miss cycle.
REQ-023 deq_valid SHALL be (count!=0); deq_pc/deq_instr driven from head entry with zero added latency; don't-care when empty.
REQ-024 On deq, head advances; count' = count + enq - deq.
REQ-025 Full with simultaneous deq: enqueue permitted, count stays DEPTH.
REQ-026 Empty: no bypass; an instruction fetched in cycle N appears on deq_* in cycle N+1 (1-cycle fetch-to-decode latency).
REQ-027 Head/tail pointers wrap modulo DEPTH; fpc wraps modulo 2^XLEN (0xFFFFFFFC + 4 -> 0x00000000).
REQ-028 redirect_valid=1: next cycle count=0, head=tail, fpc=redirect_pc with bits [$clog2(ILEN/8)-1:0] forced to 0; no enqueue that cycle; data returned that cycle discarded.
REQ-029 Redirect concurrent with deq: the head handshake completes (decode keeps that entry); all other entries discarded.
REQ-030 Redirect concurrent with exti_miss: redirect wins; stalled request abandoned.
REQ-031 Back-to-back redirects: last one defines fpc.

Reset
REQ-032 While rst=1: fpc=RESET_PC, head=tail=0, count=0, deq_valid=0, exto_addr=RESET_PC, exto_req=0 (exto_req masked by rst).
REQ-033 rst asserted mid-operation SHALL immediately (asynchronously) discard all entries and abandon any pending miss.
REQ-034 Buffer data contents need not be reset.

Verification
REQ-035 Reset release, exti_miss=0, deq_ready=0, DEPTH=4 -> entries PC 0,4,8,C enqueued; count=4 after 4 cycles; exto_req=0; fpc holds at 0x10.
REQ-036 Full queue, deq_ready=1 continuously, no misses -> one entry in/out per cycle, count stays 4, deq_pc sequence 0,4,8,C,10,14...
REQ-037 exti_miss=1 for 3 cycles at fpc=0x20 -> exto_addr=0x20 held 3 cycles, no enqueue; 4th cycle enqueues PC 0x20.
REQ-038 count=3, redirect_valid=1, redirect_pc=0x103, deq_ready=1 -> head entry consumed, next cycle count=0, exto_addr=0x100, next deq_pc=0x100.
REQ-039 fpc=0xFFFFFFFC, no miss -> entry PC 0xFFFFFFFC enqueued, next exto_addr=0x00000000.
REQ-040 rst pulsed while count=2 and exti_miss=1 -> deq_valid=0 and count=0 without waiting for clk; after release exto_addr=RESET_PC.
